ws2812_bit_decoder: RTL

WS2812_BIT_DECODER -- requirements
Module: ws2812_bit_decoder

---
 rtl/pipeline_types.sv | 11 +
 rtl/ws2812_bit_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pipeline_types.sv
// Shared pipeline types: the edge-counter record fed to the WS2812 decoder.
// The counter field is 10 bits wide.
package pipeline_types;

    typedef struct packed {
        logic [9:0] counter;
        logic       rising;
        logic       falling;
    } decoder_input_t;

endpackage

// File: rtl/ws2812_bit_decoder.sv
// Decodes WS2812 high/low pulse widths from an upstream edge counter into 24-bit GRB pixels.
// Define WS2812_DECODER_ERROR_CHECK_EN to flag illegal pulse widths on o_bit_error.
module ws2812_bit_decoder #(
    parameter int unsigned T0H_MAX   = 12,
    parameter int unsigned T1H_MIN   = 13,
    parameter int unsigned T1H_MAX   = 20,
    parameter int unsigned HIGH_MIN  = 4,
    parameter int unsigned LOW_MAX   = 40,
    parameter int unsigned RESET_MIN = 300
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  pipeline_types::decoder_input_t i_count,
    output logic [23:0]                    o_pixel,
    output logic                           o_pixel_valid,
    input  logic                           i_pixel_ready,
    output logic                           o_frame_reset,
    output logic                           o_bit_error,
    output logic                           o_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_e;

    localparam logic [9:0] T1hMin   = 10'(T1H_MIN);
    localparam logic [9:0] ResetMin = 10'(RESET_MIN);

    state_e      state_q, state_d;
    logic [23:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] pixel_q, pixel_d;
    logic        valid_q, valid_d;
    logic        frame_reset_q, frame_reset_d;
    logic        bit_error_q, bit_error_d;
    logic        overflow_q, overflow_d;

    logic        rise, fall, bit_val, pix_done, high_bad, low_bad;
    logic [23:0] word;
    logic [9:0]  cnt;

    assign cnt  = i_count.counter;
    // Simultaneous edges are treated as no edge at all.
    assign rise = i_count.rising & ~i_count.falling;
    assign fall = i_count.falling & ~i_count.rising;
    assign bit_val = (cnt >= T1hMin);
    assign word = {shift_q[22:0], bit_val};

`ifdef WS2812_DECODER_ERROR_CHECK_EN
    localparam logic [9:0] T0hMax  = 10'(T0H_MAX);
    localparam logic [9:0] T1hMax  = 10'(T1H_MAX);
    localparam logic [9:0] HighMin = 10'(HIGH_MIN);
    localparam logic [9:0] LowMax  = 10'(LOW_MAX);

    assign high_bad = (cnt < HighMin) || (cnt > T1hMax) || ((cnt > T0hMax) && (cnt < T1hMin));
    assign low_bad  = (cnt > LowMax) && (cnt < ResetMin);
`else
    logic unused_params;

    assign high_bad      = 1'b0;
    assign low_bad       = 1'b0;
    assign unused_params = ^{10'(T0H_MAX), 10'(T1H_MAX), 10'(HIGH_MIN), 10'(LOW_MAX)};
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pixel_q       <= '0;
            valid_q       <= 1'b0;
            frame_reset_q <= 1'b0;
            bit_error_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            pixel_q       <= pixel_d;
            valid_q       <= valid_d;
            frame_reset_q <= frame_reset_d;
            bit_error_q   <= bit_error_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        frame_reset_d = 1'b0;
        bit_error_d   = 1'b0;
        pix_done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rise) state_d = S_HIGH;
            end
            S_HIGH: begin
                if (fall) begin
                    if (high_bad) begin
                        bit_error_d = 1'b1;
                        bit_cnt_d   = '0;
                        state_d     = S_IDLE;
                    end else begin
                        shift_d = word;
                        state_d = S_LOW;
                        if (bit_cnt_q == 5'd23) begin
                            pix_done  = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
            end
            S_LOW: begin
                if (!(i_count.rising && i_count.falling) && (cnt >= ResetMin)) begin
                    frame_reset_d = 1'b1;
                    bit_cnt_d     = '0;
                    state_d       = S_IDLE;
                end else if (rise) begin
                    if (low_bad) begin
                        bit_error_d = 1'b1;
                        bit_cnt_d   = '0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_HIGH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        pixel_d    = pixel_q;
        valid_d    = valid_q;
        overflow_d = 1'b0;
        if (pix_done) begin
            if (!valid_q || i_pixel_ready) begin
                pixel_d = word;
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (valid_q && i_pixel_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        o_pixel       = pixel_q;
        o_pixel_valid = valid_q;
        o_frame_reset = frame_reset_q;
        o_bit_error   = bit_error_q;
        o_overflow    = overflow_q;
    end

endmodule
